memory: RTL and testbench
=========================

// Module: memory
// PURPOSE
//   Single-port synchronous byte-wide RAM, 4096 x 8, built as 4 banks of 1024 x 8.
//   Used as the general-purpose data/program store; a host drives write-enable,
//   read-enable, address and write data.
//   A bank decoder selects one bank per access from the top address bits.
// PARAMETERS
//   ADDR_WIDTH  12  total address bits (depth = 2**ADDR_WIDTH)
//   DATA_WIDTH  8   word width in bits
//   BANK_BITS   2   upper address bits used as bank select (banks = 2**BANK_BITS)
// PORTS
//   clk    in   1                rising-edge clock for all state
//   rst_n  in   1                asynchronous, active-low reset
//   we     in   1                write enable, sampled on rising clk
//   re     in   1                read enable, sampled on rising clk
//   addr   in   ADDR_WIDTH       word address; [11:10] bank, [9:0] offset
//   in     in   DATA_WIDTH       write data
//   out    out  DATA_WIDTH       registered read data
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//   - Reset: out = 0 immediately on rst_n low, held while low. Array contents are
//     NOT cleared by reset; unwritten locations read as undefined.
//   - Bank decode: bank = addr[ADDR_WIDTH-1 -: BANK_BITS];
//     offset = addr[ADDR_WIDTH-BANK_BITS-1:0]. Only the selected bank is enabled.
//   - Write: on rising clk with we=1, mem[addr] <= in. There is no write latency
//     beyond the clock edge.
//   - Read: on rising clk with re=1 and we=0, out <= mem[addr]. Latency is 1
//     cycle, so data is valid after the edge that sampled addr.
//   - Read disabled: on rising clk with re=0, out <= 0. This also applies when
//     we=1.
//   - Simultaneous we=1, re=1: the write is performed and out <= old mem[addr]
//     (read-first). There is no bypass.
//   - The address is full-range with no wrap logic. 0xFFF is the last word; every
//     value of addr is a legal access.
//   - Reset mid-operation: an access pending on the same edge is discarded and
//     out = 0. The write does not occur if rst_n is low at the edge.
//   - No X propagation into out when re=0; out is deterministic at all times
//     after reset.
// TESTING
//   1. Assert rst_n=0 with re=1 -> out=0 asynchronously. Release rst_n and
//      check out=0 until the first read.
//   2. With we=1, write A1@000, A2@200, A3@3FF, B1@400, B2@600, B3@7FF,
//      C1@800, C2@A00, C3@BFF, D1@C00, D2@E00, D3@FFF. Then set we=0, re=1 and
//      read each address -> out equals the written byte 1 cycle after addr.
//   3. Bank isolation: write 55@000, then AA@400, 800 and C00 -> a read of 000
//      returns 55. Each bank returns its own value.
//   4. Read disable: after a read of 000 (out=A1), drive re=0 -> out=0 on the
//      next edge. It stays 0 as addr changes.
//   5. Read-first: mem[123]=11; drive we=1, re=1, in=22, addr=123 -> out=11.
//      A following read of 123 with we=0 returns 22.
//   6. Reset during write: drive we=1, in=FF, addr=010 with rst_n low at the
//      edge -> mem[010] is unchanged and out=0.

Source files
------------

// File: rtl/memory.sv
// Single-port 4096 x 8 synchronous RAM organised as four 1024 x 8 banks.
// The read is registered and read-first; out is forced to zero whenever re is low.
module memory #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int BANK_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int NUM_BANKS  = 2 ** BANK_BITS;
    localparam int OFF_WIDTH  = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_DEPTH = 2 ** OFF_WIDTH;

    // One-hot enable for the bank named by the upper address bits.
    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_BITS-1:0] sel);
        logic [NUM_BANKS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

    logic [BANK_BITS-1:0]  bank_s;
    logic [OFF_WIDTH-1:0]  offset_s;
    logic [NUM_BANKS-1:0]  bank_en_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rdata_s;
    logic [DATA_WIDTH-1:0] out_r;

    assign bank_s   = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign offset_s = addr[OFF_WIDTH-1:0];

    // Bank decode and read-data selection.
    always_comb begin
        bank_en_s = bank_onehot(bank_s);
        rdata_s   = bank_rdata_s[bank_s];
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_r [BANK_DEPTH];

        // Bank storage; contents survive reset, and a write seen with rst_n low is dropped.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
            end else if (we && bank_en_s[g]) begin
                mem_r[offset_s] <= in;
            end else begin
            end
        end

        assign bank_rdata_s[g] = mem_r[offset_s];
    end

    // Registered read port: old contents are captured on the same edge as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
        end else if (re) begin
            out_r <= rdata_s;
        end else begin
            out_r <= '0;
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: a reference array supplies expected read data,
// which is queued when an access is driven and compared after the sampling edge.
module tb_memory;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [7:0]  in;
    logic [7:0]  out;

    int checks;
    int errors;

    logic [7:0] model [4096];
    logic [7:0] exp_q [$];

    memory dut (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .re   (re),
        .addr (addr),
        .in   (in),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clocked access: queue the expected output, update the model, compare after the edge.
    task automatic access(input string name, input logic w, input logic r,
                          input logic [11:0] a, input logic [7:0] d);
        logic [7:0] e;
        @(negedge clk);
        we   = w;
        re   = r;
        addr = a;
        in   = d;
        exp_q.push_back(r ? model[a] : 8'h00);
        if (w) model[a] = d;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL %s addr=%h out=%h expected=%h", name, a, out, e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we = 1'b0; re = 1'b1; addr = 12'h000; in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold out=%h expected=00", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        re = 1'b0;
        for (int i = 0; i < 3; i++) access("post_reset_idle", 1'b0, 1'b0, 12'h000, 8'h00);
    endtask

    task automatic test_write_read_banks();
        logic [11:0] a_tab [12] = '{12'h000, 12'h200, 12'h3FF, 12'h400, 12'h600, 12'h7FF,
                                    12'h800, 12'hA00, 12'hBFF, 12'hC00, 12'hE00, 12'hFFF};
        logic [7:0]  d_tab [12] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3,
                                    8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2, 8'hD3};
        for (int i = 0; i < 12; i++) access("write_only", 1'b1, 1'b0, a_tab[i], d_tab[i]);
        for (int i = 0; i < 12; i++) begin
            access("read_back", 1'b0, 1'b1, a_tab[i], 8'h00);
            checks++;
            if (out !== d_tab[i]) begin
                errors++;
                $display("FAIL read_const addr=%h out=%h expected=%h", a_tab[i], out, d_tab[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        access("pre_async_read", 1'b0, 1'b1, 12'h000, 8'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset out=%h expected=00", out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_hold out=%h expected=00", out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        access("contents_kept", 1'b0, 1'b1, 12'hFFF, 8'h00);
    endtask

    task automatic test_bank_isolation();
        access("iso_w0", 1'b1, 1'b0, 12'h000, 8'h55);
        access("iso_w1", 1'b1, 1'b0, 12'h400, 8'hAA);
        access("iso_w2", 1'b1, 1'b0, 12'h800, 8'hAA);
        access("iso_w3", 1'b1, 1'b0, 12'hC00, 8'hAA);
        access("iso_r0", 1'b0, 1'b1, 12'h000, 8'h00);
        checks++;
        if (out !== 8'h55) begin
            errors++;
            $display("FAIL iso_const out=%h expected=55", out);
        end
        access("iso_r1", 1'b0, 1'b1, 12'h400, 8'h00);
        access("iso_r2", 1'b0, 1'b1, 12'h800, 8'h00);
        access("iso_r3", 1'b0, 1'b1, 12'hC00, 8'h00);
        for (int b = 0; b < 4; b++)
            access("iso_wd", 1'b1, 1'b0, 12'(b * 1024 + 5), 8'(8'h10 + b));
        for (int b = 0; b < 4; b++)
            access("iso_rd", 1'b0, 1'b1, 12'(b * 1024 + 5), 8'h00);
    endtask

    task automatic test_read_disable();
        access("rd_restore", 1'b1, 1'b0, 12'h000, 8'hA1);
        access("rd_a1", 1'b0, 1'b1, 12'h000, 8'h00);
        access("rd_off0", 1'b0, 1'b0, 12'h000, 8'h00);
        access("rd_off1", 1'b0, 1'b0, 12'h3FF, 8'h00);
        access("rd_off2", 1'b0, 1'b0, 12'hFFF, 8'h00);
        access("rd_off_we", 1'b1, 1'b0, 12'h020, 8'h77);
        access("rd_after_we", 1'b0, 1'b1, 12'h020, 8'h00);
    endtask

    task automatic test_read_first();
        access("rf_init", 1'b1, 1'b0, 12'h123, 8'h11);
        access("rf_rw", 1'b1, 1'b1, 12'h123, 8'h22);
        checks++;
        if (out !== 8'h11) begin
            errors++;
            $display("FAIL rf_old out=%h expected=11", out);
        end
        access("rf_new", 1'b0, 1'b1, 12'h123, 8'h00);
        checks++;
        if (out !== 8'h22) begin
            errors++;
            $display("FAIL rf_new_const out=%h expected=22", out);
        end
    endtask

    task automatic test_reset_during_write();
        access("rdw_init", 1'b1, 1'b0, 12'h010, 8'h5A);
        access("rdw_prime", 1'b0, 1'b1, 12'h010, 8'h00);
        @(negedge clk);
        we = 1'b1; re = 1'b1; addr = 12'h010; in = 8'hFF;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL rdw_out out=%h expected=00", out);
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        rst_n = 1'b1;
        access("rdw_unchanged", 1'b0, 1'b1, 12'h010, 8'h00);
        checks++;
        if (out !== 8'h5A) begin
            errors++;
            $display("FAIL rdw_const out=%h expected=5A", out);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] pool [8] = '{12'h000, 12'h3FF, 12'h400, 12'h7FF,
                                  12'h800, 12'hBFF, 12'hC00, 12'hFFF};
        for (int i = 0; i < 8; i++) access("b2b_init", 1'b1, 1'b0, pool[i], 8'(i * 37 + 3));
        for (int i = 0; i < 200; i++)
            access("b2b_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pool[$urandom_range(0, 7)], 8'($urandom_range(0, 255)));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read_banks();
        test_async_reset();
        test_bank_isolation();
        test_read_disable();
        test_read_first();
        test_reset_during_write();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
